// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one combinational multiplier between NUM_REQ requesters.
// Optional per-requester grant counters are enabled with `define MULT_ARB_STATS_EN.

module multiplier #(
  parameter int unsigned bit_width = 8
) (
  input  logic [bit_width-1:0] a,
  input  logic [bit_width-1:0] b,
  output logic [bit_width-1:0] product
);
  // Low bit_width bits of the product; upper bits are dropped.
  assign product = a * b;
endmodule

module mult_arbiter #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned NUM_REQ = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*WIDTH-1:0]   req_b,
  output logic                       resp_valid,
  input  logic                       resp_ready,
  output logic [$clog2(NUM_REQ)-1:0] resp_id,
  output logic [WIDTH-1:0]           resp_result
`ifdef MULT_ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]      grant_count
`endif
);

  localparam int unsigned ID_W  = $clog2(NUM_REQ);
  localparam int unsigned SUM_W = ID_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [ID_W-1:0]    ptr;
  logic [ID_W-1:0]    id_r;
  logic [WIDTH-1:0]   a_r;
  logic [WIDTH-1:0]   b_r;
  logic [WIDTH-1:0]   product;

  logic [NUM_REQ-1:0] rot;
  logic [ID_W-1:0]    gnt_off;
  logic [SUM_W-1:0]   gnt_sum;
  logic [ID_W-1:0]    gnt_id;
  logic               gnt_found;
  logic [NUM_REQ-1:0] gnt_oh;
  logic [WIDTH-1:0]   sel_a;
  logic [WIDTH-1:0]   sel_b;
  logic               accept;
  logic               retire;

  multiplier #(
    .bit_width(WIDTH)
  ) u_mult (
    .a      (a_r),
    .b      (b_r),
    .product(product)
  );

  // Rotate requests so bit 0 is the pointer position, pick the lowest set bit,
  // then rotate the offset back into an absolute requester index.
  always_comb begin
    rot       = NUM_REQ'({req_valid, req_valid} >> ptr);
    gnt_found = |req_valid;
    gnt_off   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        gnt_off = ID_W'(k);
      end
    end
    gnt_sum = {1'b0, ptr} + {1'b0, gnt_off};
    if (gnt_sum >= SUM_W'(NUM_REQ)) begin
      gnt_sum = gnt_sum - SUM_W'(NUM_REQ);
    end
    gnt_id = gnt_sum[ID_W-1:0];
  end

  // One-hot grant and operand selection for the winning requester.
  always_comb begin
    gnt_oh = '0;
    sel_a  = '0;
    sel_b  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_found && (gnt_id == ID_W'(i))) begin
        gnt_oh[i] = 1'b1;
        sel_a     = req_a[i*WIDTH +: WIDTH];
        sel_b     = req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state plus the combinational accept handshake.
  always_comb begin
    state_next = state;
    req_ready  = '0;
    accept     = 1'b0;
    retire     = 1'b0;
    case (state)
      IDLE: begin
        if (gnt_found && !rst) begin
          req_ready  = gnt_oh;
          accept     = 1'b1;
          state_next = CALC;
        end
      end
      CALC: begin
        state_next = RESP;
      end
      RESP: begin
        if (resp_valid && resp_ready) begin
          retire     = 1'b1;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Operand capture, product capture and response handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r         <= '0;
      b_r         <= '0;
      id_r        <= '0;
      ptr         <= '0;
      resp_valid  <= 1'b0;
      resp_id     <= '0;
      resp_result <= '0;
    end else begin
      if (accept) begin
        a_r  <= sel_a;
        b_r  <= sel_b;
        id_r <= gnt_id;
      end
      if (state == CALC) begin
        resp_result <= product;
        resp_id     <= id_r;
        resp_valid  <= 1'b1;
      end
      if (retire) begin
        resp_valid <= 1'b0;
        ptr        <= (id_r == ID_W'(NUM_REQ - 1)) ? '0 : id_r + ID_W'(1);
      end
    end
  end

`ifdef MULT_ARB_STATS_EN
  // Saturating per-requester grant counters.
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_stats
    logic [15:0] cnt;
    always_ff @(posedge clk) begin
      if (rst) begin
        cnt <= '0;
      end else if (req_valid[g] && req_ready[g] && (cnt != 16'hFFFF)) begin
        cnt <= cnt + 16'd1;
      end
    end
    assign grant_count[g*16 +: 16] = cnt;
  end
`endif

endmodule

// File: tb/tb_mult_arbiter.sv
// Self-checking bench for mult_arbiter: vector table, hand sequences for reset and
// backpressure, and randomized traffic checked against a round-robin reference model.

module tb_mult_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [3:0]  req_ready;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [1:0]  resp_id;
  logic [7:0]  resp_result;
`ifdef MULT_ARB_STATS_EN
  logic [63:0] grant_count;
`endif

  int pass_cnt  = 0;
  int total_cnt = 0;
  int model_ptr = 0;

  typedef struct {
    logic [3:0]  valid;
    logic [31:0] a;
    logic [31:0] b;
    int          stall;
    int          exp_id;
    int          exp_res;
  } vec_t;

  vec_t vecs[8];

  always #5 clk = ~clk;

  mult_arbiter #(
    .WIDTH  (8),
    .NUM_REQ(4)
  ) dut (
`ifdef MULT_ARB_STATS_EN
    .grant_count(grant_count),
`endif
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_result(resp_result)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference arbiter: first valid requester searching from ptr, wrapping.
  function automatic int model_grant(input logic [3:0] m, input int p);
    for (int k = 0; k < 4; k++) begin
      int idx;
      idx = (p + k) % 4;
      if (((m >> idx) & 4'd1) != 4'd0) return idx;
    end
    return -1;
  endfunction

  function automatic int model_result(input logic [31:0] a, input logic [31:0] b, input int g);
    int av;
    int bv;
    av = int'((a >> (8 * g)) & 32'hFF);
    bv = int'((b >> (8 * g)) & 32'hFF);
    return (av * bv) % 256;
  endfunction

  // Called just after a rising edge; leaves reset deasserted in IDLE.
  task automatic do_reset();
    rst       = 1'b1;
    req_valid = 4'hF;
    @(negedge clk);
    chk("ready_in_reset", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    req_valid = '0;
    @(negedge clk);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_id", 32'(resp_id), 32'd0);
    chk("rst_resp_result", 32'(resp_result), 32'd0);
    chk("rst_idle_ready", 32'(req_ready), 32'd0);
    model_ptr = 0;
    @(posedge clk);
    #1;
  endtask

  // One full transaction starting in IDLE just after a rising edge.
  task automatic run_txn(input logic [3:0] valid, input logic [31:0] a, input logic [31:0] b,
                         input int stall, input int exp_id, input int exp_res);
    req_valid  = valid;
    req_a      = a;
    req_b      = b;
    resp_ready = (stall == 0);
    @(negedge clk);
    chk("grant", 32'(req_ready), 32'd1 << exp_id);
    @(posedge clk);
    #1;
    req_valid = '0;
    @(negedge clk);
    chk("calc_ready", 32'(req_ready), 32'd0);
    chk("calc_resp_valid", 32'(resp_valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("resp_valid", 32'(resp_valid), 32'd1);
    chk("resp_id", 32'(resp_id), 32'(exp_id));
    chk("resp_result", 32'(resp_result), 32'(exp_res));
    req_valid = 4'hF;
    for (int s = 0; s < stall; s++) begin
      @(posedge clk);
      @(negedge clk);
      chk("stall_valid", 32'(resp_valid), 32'd1);
      chk("stall_id", 32'(resp_id), 32'(exp_id));
      chk("stall_result", 32'(resp_result), 32'(exp_res));
      chk("stall_ready", 32'(req_ready), 32'd0);
    end
    req_valid  = '0;
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    model_ptr = (exp_id + 1) % 4;
  endtask

  initial begin
    vecs[0] = '{4'b0001, 32'h0000000C, 32'h0000000A, 0, 0, 120};
    vecs[1] = '{4'b0001, 32'h00000014, 32'h00000014, 0, 0, 144};
    vecs[2] = '{4'b1111, 32'h04030201, 32'h03030303, 0, 1, 6};
    vecs[3] = '{4'b1111, 32'h04030201, 32'h03030303, 0, 2, 9};
    vecs[4] = '{4'b1111, 32'h04030201, 32'h03030303, 5, 3, 12};
    vecs[5] = '{4'b1111, 32'h04030201, 32'h03030303, 0, 0, 3};
    vecs[6] = '{4'b0101, 32'h00FF0000, 32'h00FF0000, 0, 2, 1};
    vecs[7] = '{4'b0011, 32'h00000907, 32'h00000B05, 0, 0, 35};

    @(posedge clk);
    #1;
    do_reset();

    for (int v = 0; v < 8; v++) begin
      run_txn(vecs[v].valid, vecs[v].a, vecs[v].b, vecs[v].stall, vecs[v].exp_id, vecs[v].exp_res);
    end

    // Round-robin from reset with all requesters active.
    do_reset();
    for (int n = 0; n < 5; n++) begin
      run_txn(4'b1111, 32'h04030201, 32'h03030303, 0, n % 4, 3 * ((n % 4) + 1));
    end

    // Reset while an op is in CALC: no response, pointer back to 0.
    do_reset();
    run_txn(4'b0100, 32'h00050000, 32'h00070000, 0, 2, 35);
    req_valid = 4'b1000;
    req_a     = 32'h0A000000;
    req_b     = 32'h0A000000;
    @(negedge clk);
    chk("midop_grant", 32'(req_ready), 32'b1000);
    @(posedge clk);
    #1;
    rst       = 1'b1;
    req_valid = 4'hF;
    @(negedge clk);
    chk("midop_ready_rst", 32'(req_ready), 32'd0);
    chk("midop_no_resp", 32'(resp_valid), 32'd0);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    req_valid = '0;
    @(negedge clk);
    chk("midop_after_valid", 32'(resp_valid), 32'd0);
    chk("midop_after_id", 32'(resp_id), 32'd0);
    chk("midop_after_ready", 32'(req_ready), 32'd0);
    model_ptr = 0;
    @(posedge clk);
    #1;
    run_txn(4'b1100, 32'h09060000, 32'h02070000, 0, 2, 42);

`ifdef MULT_ARB_STATS_EN
    do_reset();
    for (int n = 0; n < 3; n++) begin
      run_txn(4'b0010, 32'h00000300, 32'h00000500, 0, 1, 15);
    end
    chk("stats_req0", 32'(grant_count[15:0]), 32'd0);
    chk("stats_req1", 32'(grant_count[31:16]), 32'd3);
    chk("stats_req2", 32'(grant_count[47:32]), 32'd0);
    chk("stats_req3", 32'(grant_count[63:48]), 32'd0);
`endif

    // Randomized traffic against the reference model.
    do_reset();
    for (int n = 0; n < 60; n++) begin
      logic [3:0]  m;
      logic [31:0] a;
      logic [31:0] b;
      int          g;
      int          idle;
      idle = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
      for (int i = 0; i < idle; i++) begin
        req_valid = '0;
        @(negedge clk);
        chk("idle_ready", 32'(req_ready), 32'd0);
        chk("idle_resp_valid", 32'(resp_valid), 32'd0);
        @(posedge clk);
        #1;
      end
      m = 4'($urandom_range(1, 15));
      a = $urandom;
      b = $urandom;
      g = model_grant(m, model_ptr);
      run_txn(m, a, b, int'($urandom_range(0, 3)), g, model_result(a, b, g));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
